// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_hazard_unit: registered EX operand-select forwarding and load-use       |
// | hazard control for a 4-stage ID/EX/MEM/WB pipeline.                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_use_pc,
   input  logic                  id_use_imm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  flush,
   input  logic                  mem_stall,
   output logic [1:0]            ex_sel_a,
   output logic [1:0]            ex_sel_b,
   output logic                  ex_bubble,
   output logic                  stall_id,
   output logic [CNT_W-1:0]      load_use_count
);

   localparam logic [1:0] SEL_RF     = 2'b00;
   localparam logic [1:0] SEL_EXMEM  = 2'b01;
   localparam logic [1:0] SEL_MEMWB  = 2'b10;
   localparam logic [1:0] SEL_FORCED = 2'b11;

   // Pipeline shadow entries
   logic                  ex_valid_q, ex_valid_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic                  ex_regwrite_q, ex_regwrite_d;
   logic                  ex_memread_q, ex_memread_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                  mem_regwrite_q, mem_regwrite_d;

   logic [1:0]            ex_sel_a_q, ex_sel_a_d;
   logic [1:0]            ex_sel_b_q, ex_sel_b_d;
   logic                  ex_bubble_q, ex_bubble_d;
   logic [CNT_W-1:0]      load_use_count_q, load_use_count_d;

   logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
   logic hazard;
   logic [1:0] sel_a_next, sel_b_next;

   always_comb begin
      ex_match_rs  = ex_valid_q & ex_regwrite_q & (ex_rd_q == id_rs) & id_rs_used;
      ex_match_rt  = ex_valid_q & ex_regwrite_q & (ex_rd_q == id_rt) & id_rt_used;
      mem_match_rs = mem_valid_q & mem_regwrite_q & (mem_rd_q == id_rs) & id_rs_used;
      mem_match_rt = mem_valid_q & mem_regwrite_q & (mem_rd_q == id_rt) & id_rt_used;

      // Forced operand codes do not mask the hazard; only the _used bits do.
      hazard = id_valid & ex_memread_q & (ex_match_rs | ex_match_rt) & ~flush;

      sel_a_next = SEL_RF;
      if (!id_valid)         sel_a_next = SEL_RF;
      else if (id_use_pc)    sel_a_next = SEL_FORCED;
      else if (ex_match_rs)  sel_a_next = SEL_EXMEM;
      else if (mem_match_rs) sel_a_next = SEL_MEMWB;

      sel_b_next = SEL_RF;
      if (!id_valid)         sel_b_next = SEL_RF;
      else if (id_use_imm)   sel_b_next = SEL_FORCED;
      else if (ex_match_rt)  sel_b_next = SEL_EXMEM;
      else if (mem_match_rt) sel_b_next = SEL_MEMWB;
   end

   always_comb begin
      ex_valid_d       = ex_valid_q;
      ex_rd_d          = ex_rd_q;
      ex_regwrite_d    = ex_regwrite_q;
      ex_memread_d     = ex_memread_q;
      mem_valid_d      = mem_valid_q;
      mem_rd_d         = mem_rd_q;
      mem_regwrite_d   = mem_regwrite_q;
      ex_sel_a_d       = ex_sel_a_q;
      ex_sel_b_d       = ex_sel_b_q;
      ex_bubble_d      = ex_bubble_q;
      load_use_count_d = load_use_count_q;

      if (!mem_stall) begin
         mem_valid_d    = ex_valid_q;
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         if (flush || hazard) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_bubble_d   = 1'b1;
            ex_sel_a_d    = SEL_RF;
            ex_sel_b_d    = SEL_RF;
            if (hazard && !(&load_use_count_q))
               load_use_count_d = load_use_count_q + 1'b1;
         end else begin
            ex_valid_d    = id_valid;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_bubble_d   = ~id_valid;
            ex_sel_a_d    = sel_a_next;
            ex_sel_b_d    = sel_b_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q       <= 1'b0;
         ex_rd_q          <= '0;
         ex_regwrite_q    <= 1'b0;
         ex_memread_q     <= 1'b0;
         mem_valid_q      <= 1'b0;
         mem_rd_q         <= '0;
         mem_regwrite_q   <= 1'b0;
         ex_sel_a_q       <= SEL_RF;
         ex_sel_b_q       <= SEL_RF;
         ex_bubble_q      <= 1'b1;
         load_use_count_q <= '0;
      end else begin
         ex_valid_q       <= ex_valid_d;
         ex_rd_q          <= ex_rd_d;
         ex_regwrite_q    <= ex_regwrite_d;
         ex_memread_q     <= ex_memread_d;
         mem_valid_q      <= mem_valid_d;
         mem_rd_q         <= mem_rd_d;
         mem_regwrite_q   <= mem_regwrite_d;
         ex_sel_a_q       <= ex_sel_a_d;
         ex_sel_b_q       <= ex_sel_b_d;
         ex_bubble_q      <= ex_bubble_d;
         load_use_count_q <= load_use_count_d;
      end
   end

   assign ex_sel_a       = ex_sel_a_q;
   assign ex_sel_b       = ex_sel_b_q;
   assign ex_bubble      = ex_bubble_q;
   assign stall_id       = hazard;
   assign load_use_count = load_use_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fwd_hazard_unit: directed self-checking bench for fwd_hazard_unit.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs_used, id_rt_used, id_use_pc, id_use_imm;
   logic [2:0] id_rs, id_rt, id_rd;
   logic       id_regwrite, id_memread, flush, mem_stall;
   logic [1:0] ex_sel_a, ex_sel_b, s_sel_a, s_sel_b;
   logic       ex_bubble, stall_id, s_bubble, s_stall;
   logic [15:0] load_use_count;
   logic [1:0]  s_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_ADDR_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_pc(id_use_pc),
      .id_use_imm(id_use_imm), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .mem_stall(mem_stall),
      .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_bubble(ex_bubble),
      .stall_id(stall_id), .load_use_count(load_use_count)
   );

   // Narrow counter instance so saturation is reachable in a few hazards.
   fwd_hazard_unit #(.REG_ADDR_W(3), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_pc(id_use_pc),
      .id_use_imm(id_use_imm), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .mem_stall(mem_stall),
      .ex_sel_a(s_sel_a), .ex_sel_b(s_sel_b), .ex_bubble(s_bubble),
      .stall_id(s_stall), .load_use_count(s_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // valid, rs, rs_used, rt, rt_used, use_pc, use_imm, rd, regwrite, memread
   task automatic drive_id(input logic v, input logic [2:0] rs, input logic rsu,
                           input logic [2:0] rt, input logic rtu, input logic upc,
                           input logic uimm, input logic [2:0] rd, input logic rw,
                           input logic mr);
      id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_use_pc = upc; id_use_imm = uimm; id_rd = rd; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      total_cnt++; if (ex_sel_a !== 2'b00) $display("FAIL reset_sel_a: got %b want 00", ex_sel_a); else pass_cnt++;
      total_cnt++; if (ex_sel_b !== 2'b00) $display("FAIL reset_sel_b: got %b want 00", ex_sel_b); else pass_cnt++;
      total_cnt++; if (ex_bubble !== 1'b1) $display("FAIL reset_bubble: got %b want 1", ex_bubble); else pass_cnt++;
      total_cnt++; if (stall_id !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_id); else pass_cnt++;
      total_cnt++; if (load_use_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", load_use_count); else pass_cnt++;
      total_cnt++; if (s_count !== 2'd0 || s_bubble !== 1'b1) $display("FAIL reset_sat: got cnt=%0d bub=%b want 0/1", s_count, s_bubble); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      drive_id(1, 1, 1, 2, 1, 0, 0, 3, 1, 0);       // I1: writes R3
      step();
      total_cnt++; if (ex_bubble !== 1'b0 || ex_sel_a !== 2'b00) $display("FAIL b2b_i1: got bub=%b a=%b want 0/00", ex_bubble, ex_sel_a); else pass_cnt++;
      drive_id(1, 3, 1, 4, 1, 0, 0, 6, 1, 0);       // I2: reads rs=R3
      step();
      total_cnt++; if (ex_sel_a !== 2'b01) $display("FAIL b2b_i2_sel_a: got %b want 01", ex_sel_a); else pass_cnt++;
      total_cnt++; if (ex_sel_b !== 2'b00) $display("FAIL b2b_i2_sel_b: got %b want 00", ex_sel_b); else pass_cnt++;
      drive_id(1, 7, 1, 3, 1, 0, 0, 7, 1, 0);       // I3: reads rt=R3, I1 now in MEM
      step();
      total_cnt++; if (ex_sel_b !== 2'b10) $display("FAIL b2b_i3_sel_b: got %b want 10", ex_sel_b); else pass_cnt++;
      total_cnt++; if (ex_sel_a !== 2'b00) $display("FAIL b2b_i3_sel_a: got %b want 00", ex_sel_a); else pass_cnt++;
   endtask

   task automatic test_double_match();
      drive_id(1, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      step();
      drive_id(1, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      step();
      drive_id(1, 2, 1, 2, 0, 0, 0, 1, 1, 0);       // rt=R2 but rt unused
      step();
      total_cnt++; if (ex_sel_a !== 2'b01) $display("FAIL dbl_sel_a: got %b want 01", ex_sel_a); else pass_cnt++;
      total_cnt++; if (ex_sel_b !== 2'b00) $display("FAIL dbl_unused_sel_b: got %b want 00", ex_sel_b); else pass_cnt++;
   endtask

   task automatic test_load_use();
      drive_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 1);       // load R5
      step();
      drive_id(1, 0, 0, 5, 1, 0, 0, 4, 1, 0);       // user reads rt=R5
      #1;
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_id); else pass_cnt++;
      step();
      total_cnt++; if (ex_bubble !== 1'b1) $display("FAIL lu_bubble: got %b want 1", ex_bubble); else pass_cnt++;
      total_cnt++; if (load_use_count !== 16'd1) $display("FAIL lu_count: got %0d want 1", load_use_count); else pass_cnt++;
      total_cnt++; if (stall_id !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", stall_id); else pass_cnt++;
      step();
      total_cnt++; if (ex_sel_b !== 2'b10 || ex_bubble !== 1'b0) $display("FAIL lu_resume: got b=%b bub=%b want 10/0", ex_sel_b, ex_bubble); else pass_cnt++;
      total_cnt++; if (load_use_count !== 16'd1) $display("FAIL lu_count_hold: got %0d want 1", load_use_count); else pass_cnt++;
   endtask

   task automatic test_forced();
      drive_id(1, 4, 1, 4, 1, 0, 1, 7, 1, 0);       // imm forces B; A forwards from EX
      step();
      total_cnt++; if (ex_sel_b !== 2'b11) $display("FAIL forced_sel_b: got %b want 11", ex_sel_b); else pass_cnt++;
      total_cnt++; if (ex_sel_a !== 2'b01) $display("FAIL forced_sel_a: got %b want 01", ex_sel_a); else pass_cnt++;
      drive_id(1, 0, 0, 0, 0, 0, 0, 6, 1, 1);       // load R6
      step();
      drive_id(1, 6, 1, 0, 0, 1, 0, 0, 0, 0);       // use_pc set, rs still used
      #1;
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL forced_pc_hazard: got %b want 1", stall_id); else pass_cnt++;
      flush = 1'b1;
      #1;
      total_cnt++; if (stall_id !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_id); else pass_cnt++;
      step();
      flush = 1'b0;
      total_cnt++; if (ex_bubble !== 1'b1 || ex_sel_a !== 2'b00) $display("FAIL flush_bubble: got bub=%b a=%b want 1/00", ex_bubble, ex_sel_a); else pass_cnt++;
      total_cnt++; if (load_use_count !== 16'd1) $display("FAIL flush_count: got %0d want 1", load_use_count); else pass_cnt++;
   endtask

   task automatic test_freeze();
      drive_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);       // K1 writes R3
      step();
      drive_id(1, 3, 1, 0, 0, 0, 0, 5, 1, 0);       // K2 reads R3, writes R5
      step();
      mem_stall = 1'b1; flush = 1'b1;
      drive_id(1, 3, 1, 5, 1, 1, 0, 2, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (ex_sel_a !== 2'b01 || ex_sel_b !== 2'b00 || ex_bubble !== 1'b0 || load_use_count !== 16'd1)
            $display("FAIL freeze_%0d: got a=%b b=%b bub=%b cnt=%0d want 01/00/0/1", i, ex_sel_a, ex_sel_b, ex_bubble, load_use_count);
         else pass_cnt++;
      end
      mem_stall = 1'b0; flush = 1'b0;
      drive_id(1, 3, 1, 5, 1, 0, 0, 2, 1, 0);       // K3: K1 must still be in MEM
      step();
      total_cnt++; if (ex_sel_a !== 2'b10 || ex_sel_b !== 2'b01) $display("FAIL unfreeze: got a=%b b=%b want 10/01", ex_sel_a, ex_sel_b); else pass_cnt++;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         drive_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 1);
         step();
         drive_id(1, 0, 0, 5, 1, 0, 0, 1, 1, 0);
         #1;
         total_cnt++; if (stall_id !== 1'b1) $display("FAIL sat_stall_%0d: got %b want 1", i, stall_id); else pass_cnt++;
         step();
         step();
      end
      total_cnt++; if (load_use_count !== 16'd4) $display("FAIL sat_wide_count: got %0d want 4", load_use_count); else pass_cnt++;
      total_cnt++; if (s_count !== 2'd3) $display("FAIL sat_narrow_count: got %0d want 3", s_count); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      drive_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 1);
      step();
      drive_id(1, 5, 1, 0, 0, 0, 0, 1, 1, 0);
      #1;
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL rms_stall: got %b want 1", stall_id); else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++; if (stall_id !== 1'b0 || ex_bubble !== 1'b1) $display("FAIL rms_state: got stall=%b bub=%b want 0/1", stall_id, ex_bubble); else pass_cnt++;
      total_cnt++; if (load_use_count !== 16'd0) $display("FAIL rms_count: got %0d want 0", load_use_count); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_double_match();
      test_load_use();
      test_forced();
      test_freeze();
      test_saturation();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
